// File: rtl/drap_imem_decode.sv
// Instruction-side responder for DRAP_Ifetch: loadable word memory, one-cycle fetch,
// combinational decode into Ifetch controls, wrong-path squash and halt/error handling.
module drap_imem_decode #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [5:0]  OP_BEQ    = 6'h04,
    parameter logic [5:0]  OP_J      = 6'h02
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              start,
    input  logic [31:0]       pc_in,
    input  logic              zero_in,
    output logic [31:0]       instr_word,
    output logic              instr_valid,
    output logic [25:0]       instruction,
    output logic [29:0]       sign_ext_out,
    output logic              br_out,
    output logic              jmp_out,
    output logic              running,
    output logic              halted,
    output logic              err,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       squash_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic [5:0]        opcode;
    logic              bad_pc;
    logic              halt_hit;
    logic              redirect;
    logic              fetch_ok;

    assign rd_addr  = pc_in[ADDR_W+1:2];
    assign bad_pc   = (pc_in[1:0] != 2'b00) || (pc_in[31:ADDR_W+2] != '0);
    assign opcode   = instr_word[31:26];
    assign halt_hit = instr_valid && (instr_word == HALT_WORD);

    // The halt word must never steer the fetch unit, whatever opcodes are chosen.
    assign br_out       = instr_valid && !halt_hit && (opcode == OP_BEQ);
    assign jmp_out      = instr_valid && !halt_hit && (opcode == OP_J);
    assign instruction  = instr_word[25:0];
    assign sign_ext_out = {{14{instr_word[15]}}, instr_word[15:0]};
    assign redirect     = jmp_out || (br_out && zero_in);

    assign running = (state == S_RUN);
    assign halted  = (state == S_HALT);

    // NOTE: the memory array has no reset branch; a reset only restarts the
    // controller, so a preloaded program survives it and the array maps to RAM.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // NOTE: every variable gets a default before the case, so no path through
    // this block leaves a value held and no latch is inferred.
    always_comb begin
        state_next = state;
        fetch_ok   = 1'b0;
        unique case (state)
            S_LOAD: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                fetch_ok = !bad_pc && !halt_hit && !redirect;
                if (bad_pc || halt_hit) begin
                    state_next = S_HALT;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_LOAD;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_LOAD;
            instr_word  <= '0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
            fetch_cnt   <= '0;
            squash_cnt  <= '0;
        end else begin
            state <= state_next;
            if (state == S_RUN) begin
                // The word is always captured; only its valid flag decides whether it is live.
                instr_word  <= mem[rd_addr];
                instr_valid <= fetch_ok;
                if (fetch_ok) begin
                    fetch_cnt <= fetch_cnt + 16'd1;
                end
                if (redirect) begin
                    squash_cnt <= squash_cnt + 16'd1;
                end
                if (bad_pc) begin
                    err <= 1'b1;
                end
            end else begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_drap_imem_decode.sv
// Directed bench for drap_imem_decode: load, fetch, branch/jump squash, bad PC,
// halt word and reset-with-memory-retention, all against hand-computed values.
module tb_drap_imem_decode;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_data;
    logic              start;
    logic [31:0]       pc_in;
    logic              zero_in;
    logic [31:0]       instr_word;
    logic              instr_valid;
    logic [25:0]       instruction;
    logic [29:0]       sign_ext_out;
    logic              br_out;
    logic              jmp_out;
    logic              running;
    logic              halted;
    logic              err;
    logic [15:0]       fetch_cnt;
    logic [15:0]       squash_cnt;

    int total = 0;
    int bad   = 0;

    drap_imem_decode #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .pc_in       (pc_in),
        .zero_in     (zero_in),
        .instr_word  (instr_word),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .sign_ext_out(sign_ext_out),
        .br_out      (br_out),
        .jmp_out     (jmp_out),
        .running     (running),
        .halted      (halted),
        .err         (err),
        .fetch_cnt   (fetch_cnt),
        .squash_cnt  (squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it, so inputs and checks sit away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst   = 1'b0;
        start = 1'b0;
        repeat (cycles) tick();
        rst = 1'b1;
    endtask

    // One LOAD->RUN edge; the fetch PC is already presented for the first RUN edge.
    task automatic go(input logic [31:0] first_pc);
        start = 1'b1;
        pc_in = first_pc;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        pc_in     = '0;
        zero_in   = 1'b0;

        do_reset(2);
        check("rst_word",   instr_word,   32'h0);
        check("rst_valid",  instr_valid,  1'b0);
        check("rst_instr",  instruction,  26'h0);
        check("rst_sext",   sign_ext_out, 30'h0);
        check("rst_br",     br_out,       1'b0);
        check("rst_jmp",    jmp_out,      1'b0);
        check("rst_run",    running,      1'b0);
        check("rst_halt",   halted,       1'b0);
        check("rst_err",    err,          1'b0);
        check("rst_fcnt",   fetch_cnt,    16'h0);
        check("rst_scnt",   squash_cnt,   16'h0);

        load_word(8'd0, 32'h012A_4020);
        load_word(8'd1, 32'h1000_0003);
        load_word(8'd2, 32'h1000_FFFE);
        load_word(8'd3, 32'h0800_0040);
        load_word(8'd4, 32'h0000_0000);
        load_word(8'd5, 32'hFFFF_FFFF);
        check("load_valid", instr_valid, 1'b0);

        // A reset between load and run must keep the program.
        do_reset(2);

        // Writes attempted while running must be ignored.
        go(32'h0);
        prog_we   = 1'b1;
        prog_addr = 8'd0;
        prog_data = 32'hDEAD_BEEF;
        check("go_run", running, 1'b1);
        tick();
        check("f0_word",  instr_word,  32'h012A_4020);
        check("f0_valid", instr_valid, 1'b1);
        check("f0_br",    br_out,      1'b0);
        check("f0_fcnt",  fetch_cnt,   16'd1);

        pc_in = 32'h4;
        tick();
        check("f1_br",    br_out,       1'b1);
        check("f1_sext",  sign_ext_out, 30'h3);
        check("f1_instr", instruction,  26'h000_0003);
        check("f1_fcnt",  fetch_cnt,    16'd2);

        // Branch not taken: the next fetch stays live.
        pc_in   = 32'h8;
        zero_in = 1'b0;
        tick();
        check("f2_word",  instr_word,   32'h1000_FFFE);
        check("f2_valid", instr_valid,  1'b1);
        check("f2_sext",  sign_ext_out, 30'h3FFF_FFFE);
        check("f2_br",    br_out,       1'b1);
        check("f2_scnt",  squash_cnt,   16'd0);

        // Branch taken: the wrong-path word (mem[3], a jump) is stored dead.
        pc_in   = 32'hC;
        zero_in = 1'b1;
        tick();
        check("sq1_valid", instr_valid, 1'b0);
        check("sq1_jmp",   jmp_out,     1'b0);
        check("sq1_scnt",  squash_cnt,  16'd1);
        check("sq1_fcnt",  fetch_cnt,   16'd3);

        pc_in = 32'h8;
        tick();
        check("f3_br",    br_out,    1'b1);
        check("f3_fcnt",  fetch_cnt, 16'd4);

        // Same branch with zero_in low: no squash.
        pc_in   = 32'hC;
        zero_in = 1'b0;
        tick();
        check("f4_valid", instr_valid, 1'b1);
        check("f4_jmp",   jmp_out,     1'b1);
        check("f4_instr", instruction, 26'h000_0040);
        check("f4_scnt",  squash_cnt,  16'd1);
        check("f4_fcnt",  fetch_cnt,   16'd5);

        // Jump always redirects.
        pc_in = 32'h10;
        tick();
        check("sq2_valid", instr_valid, 1'b0);
        check("sq2_jmp",   jmp_out,     1'b0);
        check("sq2_scnt",  squash_cnt,  16'd2);
        check("sq2_fcnt",  fetch_cnt,   16'd5);
        prog_we = 1'b0;

        // Reset mid-run: counters clear, memory survives.
        do_reset(1);
        check("mr_run",  running,    1'b0);
        check("mr_fcnt", fetch_cnt,  16'd0);
        check("mr_scnt", squash_cnt, 16'd0);
        check("mr_word", instr_word, 32'h0);
        go(32'h0);
        tick();
        check("mr_f0_word",  instr_word,  32'h012A_4020);
        check("mr_f0_valid", instr_valid, 1'b1);

        // Out-of-range PC halts with err and a dead word; counters then freeze.
        pc_in = 32'h0000_0400;
        tick();
        check("oor_err",   err,         1'b1);
        check("oor_halt",  halted,      1'b1);
        check("oor_valid", instr_valid, 1'b0);
        check("oor_fcnt",  fetch_cnt,   16'd1);
        pc_in = 32'h4;
        tick();
        check("hold_halt", halted,    1'b1);
        check("hold_fcnt", fetch_cnt, 16'd1);
        check("hold_br",   br_out,    1'b0);

        // Write and start in the same LOAD cycle, then run into the halt word.
        do_reset(1);
        prog_we   = 1'b1;
        prog_addr = 8'd6;
        prog_data = 32'h1234_5678;
        go(32'h18);
        prog_we = 1'b0;
        tick();
        check("ws_word",  instr_word,  32'h1234_5678);
        check("ws_valid", instr_valid, 1'b1);
        pc_in = 32'h14;
        tick();
        check("hw_word",  instr_word,  32'hFFFF_FFFF);
        check("hw_valid", instr_valid, 1'b1);
        check("hw_br",    br_out,      1'b0);
        check("hw_jmp",   jmp_out,     1'b0);
        check("hw_fcnt",  fetch_cnt,   16'd2);
        check("hw_halt0", halted,      1'b0);
        pc_in = 32'h0;
        tick();
        check("hw_halt",  halted,      1'b1);
        check("hw_err",   err,         1'b0);
        check("hw_valid1", instr_valid, 1'b0);
        check("hw_fcnt1", fetch_cnt,   16'd2);

        // Misaligned PC.
        do_reset(1);
        go(32'h2);
        tick();
        check("mis_err",   err,         1'b1);
        check("mis_halt",  halted,      1'b1);
        check("mis_valid", instr_valid, 1'b0);
        check("mis_fcnt",  fetch_cnt,   16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
